imm_gen_pipe: RTL and testbench
===============================

IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 64, immediate width; legal values 32 and 64 only.
REQ-002 Parameter TAG_W, default 64, width of the sideband tag carried with each instruction (e.g. PC).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  producer offers inst/fmt_op/tag this cycle.
REQ-006 in_ready  output  1  block accepts offer this cycle.
REQ-007 inst  input  32  raw RV instruction word.
REQ-008 fmt_op  input  3  format select: 000 none, 001 I, 010 S, 011 B, 100 U, 101 J, 110 Z (CSR uimm), 111 AUTO.
REQ-009 tag_in  input  TAG_W  sideband, passed unmodified.
REQ-010 flush  input  1  synchronous drop of all buffered entries.
REQ-011 out_valid  output  1  imm_val/tag_out/fmt_err valid.
REQ-012 out_ready  input  1  consumer takes output this cycle.
REQ-013 imm_val  output  XLEN  generated immediate.
REQ-014 tag_out  output  TAG_W  tag of the entry presented.
REQ-015 fmt_err  output  1  AUTO mode found no immediate-bearing opcode.

Function
REQ-016 Transfer occurs on in_valid&in_ready (accept) and out_valid&out_ready (retire).
REQ-017 Latency: accepted entry is presentable at out_valid the cycle after acceptance, never earlier.
REQ-018 Storage: 2-entry FIFO (skid); in_ready = entry count < 2, registered-independent of out_ready (no combinational in->out path).
REQ-019 Simultaneous accept and retire with count 2 not possible (in_ready=0); with count 1 count stays 1, order preserved.
REQ-020 Output order strictly equals accept order; out_* held stable while out_valid&!out_ready.
REQ-021 Immediate computed at accept and stored; no recompute on output side.
REQ-022 I: sext(inst[31:20]). S: sext({inst[31:25],inst[11:7]}). B: sext({inst[31],inst[7],inst[30:25],inst[11:8],0}).
REQ-023 U: sext({inst[31:12],12'b0}) to XLEN (upper bits copy inst[31] when XLEN=64). J: sext({inst[31],inst[19:12],inst[20],inst[30:21],0}).
REQ-024 Z: zero-extend inst[19:15]. none (000): all zeros, fmt_err=0.
REQ-025 AUTO from inst[6:0]: 0010011/0000011/1100111/0011011 -> I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 1110011 with inst[14]=1 -> Z, inst[14]=0 -> I.
REQ-026 AUTO with any other opcode: imm_val=0, fmt_err=1; entry still flows normally. Explicit fmt_op never sets fmt_err.
REQ-027 flush: next cycle count=0, out_valid=0, in_ready=1; an offer in the flush cycle is dropped; a retire in the flush cycle still counts as taken.
REQ-028 Head/tail pointers 1 bit each, wrap 1->0.

Reset
REQ-029 While rst_n=0: count=0, pointers=0, out_valid=0, in_ready=0, imm_val=0, tag_out=0, fmt_err=0.
REQ-030 First cycle after rst_n deasserts in_ready=1; reset mid-operation discards all entries with no output.

Structure
REQ-031 Package imm_pkg holds fmt_op enum (FMT_NONE..FMT_AUTO) and RV opcode constants.
REQ-032 Sub-module imm_extract: purely combinational (inst, fmt_op) -> (imm, fmt_err), parametrised by XLEN; imm_gen_pipe instantiates it once plus the FIFO.

Verification
REQ-033 I: inst=0xFFF00093, fmt_op=001, out_ready=1 -> next cycle out_valid=1, imm_val=0xFFFFFFFFFFFFFFFF.
REQ-034 B: inst=0xFE000EE3, fmt_op=011 -> imm_val=0xFFFFFFFFFFFFFFFC; AUTO gives same, fmt_err=0.
REQ-035 U AUTO: inst=0x800000B7, XLEN=64 -> 0xFFFFFFFF80000000; XLEN=32 -> 0x80000000; inst=0x0000000B AUTO -> imm 0, fmt_err=1.
REQ-036 Backpressure: out_ready=0, offer tags 1,2,3 back-to-back -> 1,2 accepted, in_ready=0 on 3rd; release -> outputs 1,2,3 in order, no loss/duplication.
REQ-037 Flush with count=2 and in_valid=1 -> next cycle out_valid=0, in_ready=1, no entry ever emitted.
REQ-038 rst_n pulsed low with count=1 mid-stream -> all outputs zero during reset, no stale entry after release.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared types for the immediate generator: the format-select encoding and the
// RV32/RV64 base opcodes used when the format is decoded from the instruction.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE = 3'b000,
        FMT_I    = 3'b001,
        FMT_S    = 3'b010,
        FMT_B    = 3'b011,
        FMT_U    = 3'b100,
        FMT_J    = 3'b101,
        FMT_Z    = 3'b110,
        FMT_AUTO = 3'b111
    } fmt_op_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus of the immediate generator: instruction offers in, immediates out.
// The master side is the surrounding pipeline, the slave side is imm_gen_pipe.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      inst;
    logic [2:0]       fmt_op;
    logic [TAG_W-1:0] tag_in;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  imm_val;
    logic [TAG_W-1:0] tag_out;
    logic             fmt_err;

    modport master (
        output in_valid, inst, fmt_op, tag_in, flush, out_ready,
        input  in_ready, out_valid, imm_val, tag_out, fmt_err
    );

    modport slave (
        input  in_valid, inst, fmt_op, tag_in, flush, out_ready,
        output in_ready, out_valid, imm_val, tag_out, fmt_err
    );
endinterface

// File: rtl/imm_extract.sv
// Combinational immediate extraction for one RV instruction word, with optional
// format auto-detection from the opcode.
module imm_extract
    import imm_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     inst,
    input  logic [2:0]      fmt_op,
    output logic [XLEN-1:0] imm,
    output logic            fmt_err
);

    fmt_op_e     eff_fmt;
    logic [31:0] imm32;

    // AUTO resolves to a concrete format first; unknown opcodes fall back to a zero immediate.
    always_comb begin
        eff_fmt = fmt_op_e'(fmt_op);
        fmt_err = 1'b0;
        if (fmt_op_e'(fmt_op) == FMT_AUTO) begin
            case (inst[6:0])
                OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: eff_fmt = FMT_I;
                OP_STORE:                           eff_fmt = FMT_S;
                OP_BRANCH:                          eff_fmt = FMT_B;
                OP_LUI, OP_AUIPC:                   eff_fmt = FMT_U;
                OP_JAL:                             eff_fmt = FMT_J;
                OP_SYSTEM:                          eff_fmt = inst[14] ? FMT_Z : FMT_I;
                default: begin
                    eff_fmt = FMT_NONE;
                    fmt_err = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        imm32 = '0;
        case (eff_fmt)
            FMT_I: imm32 = {{20{inst[31]}}, inst[31:20]};
            FMT_S: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            FMT_B: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            FMT_U: imm32 = {inst[31:12], 12'b0};
            FMT_J: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            FMT_Z: imm32 = {27'b0, inst[19:15]};
            default: imm32 = '0;
        endcase
    end

    // Bit 31 of every format is already the correct sign, so widening is a plain sign extension.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Immediate generator stage: extracts the immediate at accept time and buffers
// results with their tags in a 2-entry skid FIFO.
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    imm_gen_pipe_if.slave bus
);

    logic [XLEN-1:0]  imm_mem [2];
    logic [TAG_W-1:0] tag_mem [2];
    logic [1:0]       err_mem;
    logic             head;
    logic             tail;
    logic [1:0]       count;
    logic [XLEN-1:0]  new_imm;
    logic             new_err;
    logic             accept;
    logic             retire;

    imm_extract #(.XLEN(XLEN)) u_extract (
        .inst    (bus.inst),
        .fmt_op  (bus.fmt_op),
        .imm     (new_imm),
        .fmt_err (new_err)
    );

    // Ready depends only on occupancy, never on out_ready, and is held low throughout reset.
    assign bus.in_ready  = rst_n && (count != 2'd2);
    assign bus.out_valid = (count != 2'd0);
    assign bus.imm_val   = bus.out_valid ? imm_mem[head] : '0;
    assign bus.tag_out   = bus.out_valid ? tag_mem[head] : '0;
    assign bus.fmt_err   = bus.out_valid ? err_mem[head] : 1'b0;

    assign accept = bus.in_valid && bus.in_ready && !bus.flush;
    assign retire = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 2'd0;
            head    <= 1'b0;
            tail    <= 1'b0;
            err_mem <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                imm_mem[i] <= '0;
                tag_mem[i] <= '0;
            end
        end else if (bus.flush) begin
            count <= 2'd0;
            head  <= 1'b0;
            tail  <= 1'b0;
        end else begin
            if (accept) begin
                imm_mem[tail] <= new_imm;
                tag_mem[tail] <= bus.tag_in;
                err_mem[tail] <= new_err;
                tail          <= tail + 1'b1;
            end
            if (retire) begin
                head <= head + 1'b1;
            end
            case ({accept, retire})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: format decode, XLEN=32 widening, backpressure
// ordering, flush and mid-stream reset, all against hand-computed values.
module tb_imm_gen_pipe;
    import imm_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(64), .TAG_W(64)) bus ();
    imm_gen_pipe_if #(.XLEN(32), .TAG_W(64)) bus32 ();

    imm_gen_pipe #(.XLEN(64), .TAG_W(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(64)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus32.slave)
    );

    typedef struct {
        logic [31:0] inst;
        logic [2:0]  fmt;
        logic [63:0] imm;
        logic        err;
    } vec_t;

    vec_t vecs [14] = '{
        '{32'hFFF00093, FMT_I,    64'hFFFFFFFFFFFFFFFF, 1'b0},
        '{32'hFFF00093, FMT_AUTO, 64'hFFFFFFFFFFFFFFFF, 1'b0},
        '{32'hFE000EE3, FMT_B,    64'hFFFFFFFFFFFFFFFC, 1'b0},
        '{32'hFE000EE3, FMT_AUTO, 64'hFFFFFFFFFFFFFFFC, 1'b0},
        '{32'h800000B7, FMT_AUTO, 64'hFFFFFFFF80000000, 1'b0},
        '{32'h800000B7, FMT_U,    64'hFFFFFFFF80000000, 1'b0},
        '{32'h0000000B, FMT_AUTO, 64'h0000000000000000, 1'b1},
        '{32'h7FF0000B, FMT_I,    64'h00000000000007FF, 1'b0},
        '{32'h02000223, FMT_S,    64'h0000000000000024, 1'b0},
        '{32'h8000006F, FMT_AUTO, 64'hFFFFFFFFFFF00000, 1'b0},
        '{32'h000FD073, FMT_AUTO, 64'h000000000000001F, 1'b0},
        '{32'h80001073, FMT_AUTO, 64'hFFFFFFFFFFFFF800, 1'b0},
        '{32'hFFFFFFFF, FMT_NONE, 64'h0000000000000000, 1'b0},
        '{32'hFFFFFFFF, FMT_Z,    64'h000000000000001F, 1'b0}
    };

    task automatic idle_inputs();
        bus.in_valid    = 1'b0;
        bus.inst        = '0;
        bus.fmt_op      = '0;
        bus.tag_in      = '0;
        bus.flush       = 1'b0;
        bus.out_ready   = 1'b0;
        bus32.in_valid  = 1'b0;
        bus32.inst      = '0;
        bus32.fmt_op    = '0;
        bus32.tag_in    = '0;
        bus32.flush     = 1'b0;
        bus32.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        bus.in_valid = 1'b1;
        bus.inst     = 32'hFFF00093;
        bus.fmt_op   = FMT_I;
        bus.tag_in   = 64'h77;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_in_ready: got %b expected 0", bus.in_ready);
        end
        total++;
        if (bus.out_valid !== 1'b0 || bus.imm_val !== 64'h0 || bus.tag_out !== 64'h0 || bus.fmt_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got v=%b imm=%h tag=%h err=%b expected all zero",
                     bus.out_valid, bus.imm_val, bus.tag_out, bus.fmt_err);
        end
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset: got ready=%b valid=%b expected ready=1 valid=0",
                     bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_decode();
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid  = 1'b1;
            bus.inst      = vecs[i].inst;
            bus.fmt_op    = vecs[i].fmt;
            bus.tag_in    = 64'hA5A5000000000000 | 64'(i);
            bus.out_ready = 1'b1;
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                bad++;
                $display("[TB] FAIL decode%0d_early: got valid=%b ready=%b expected valid=0 ready=1",
                         i, bus.out_valid, bus.in_ready);
            end
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL decode%0d_valid: got %b expected 1", i, bus.out_valid);
            end
            total++;
            if (bus.imm_val !== vecs[i].imm) begin
                bad++;
                $display("[TB] FAIL decode%0d_imm: got %h expected %h", i, bus.imm_val, vecs[i].imm);
            end
            total++;
            if (bus.fmt_err !== vecs[i].err) begin
                bad++;
                $display("[TB] FAIL decode%0d_err: got %b expected %b", i, bus.fmt_err, vecs[i].err);
            end
            total++;
            if (bus.tag_out !== (64'hA5A5000000000000 | 64'(i))) begin
                bad++;
                $display("[TB] FAIL decode%0d_tag: got %h expected %h", i, bus.tag_out,
                         64'hA5A5000000000000 | 64'(i));
            end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
    endtask

    task automatic test_xlen32();
        logic [31:0] x_inst [3] = '{32'h800000B7, 32'hFFF00093, 32'h0000000B};
        logic [2:0]  x_fmt  [3] = '{FMT_AUTO, FMT_I, FMT_AUTO};
        logic [31:0] x_imm  [3] = '{32'h80000000, 32'hFFFFFFFF, 32'h00000000};
        logic        x_err  [3] = '{1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus32.in_valid  = 1'b1;
            bus32.inst      = x_inst[i];
            bus32.fmt_op    = x_fmt[i];
            bus32.tag_in    = 64'(i + 100);
            bus32.out_ready = 1'b1;
            @(posedge clk);
            #1 bus32.in_valid = 1'b0;
            @(negedge clk);
            total++;
            if (bus32.out_valid !== 1'b1 || bus32.imm_val !== x_imm[i] || bus32.fmt_err !== x_err[i]) begin
                bad++;
                $display("[TB] FAIL xlen32_%0d: got v=%b imm=%h err=%b expected v=1 imm=%h err=%b",
                         i, bus32.out_valid, bus32.imm_val, bus32.fmt_err, x_imm[i], x_err[i]);
            end
        end
        @(posedge clk);
        #1 bus32.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] b_inst [3] = '{32'hFFF00093, 32'h02000223, 32'h8000006F};
        logic [2:0]  b_fmt  [3] = '{FMT_I, FMT_S, FMT_J};
        logic [63:0] b_imm  [3] = '{64'hFFFFFFFFFFFFFFFF, 64'h24, 64'hFFFFFFFFFFF00000};
        logic        exp_ready [3] = '{1'b1, 1'b1, 1'b0};
        logic [63:0] got_tag [3];
        logic [63:0] got_imm [3];
        int          got = 0;
        logic        send_now;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.inst     = b_inst[i];
            bus.fmt_op   = b_fmt[i];
            bus.tag_in   = 64'(i + 1);
            @(negedge clk);
            total++;
            if (bus.in_ready !== exp_ready[i]) begin
                bad++;
                $display("[TB] FAIL bp_ready%0d: got %b expected %b", i, bus.in_ready, exp_ready[i]);
            end
            if (i > 0) begin
                total++;
                if (bus.tag_out !== 64'h1 || bus.imm_val !== b_imm[0]) begin
                    bad++;
                    $display("[TB] FAIL bp_hold%0d: got tag=%h imm=%h expected tag=1 imm=%h",
                             i, bus.tag_out, bus.imm_val, b_imm[0]);
                end
            end
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && got < 3; c++) begin
            @(negedge clk);
            if (bus.out_valid && bus.out_ready) begin
                got_tag[got] = bus.tag_out;
                got_imm[got] = bus.imm_val;
                got++;
            end
            send_now = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (send_now) bus.in_valid = 1'b0;
        end
        total++;
        if (got != 3) begin
            bad++;
            $display("[TB] FAIL bp_count: got %0d outputs expected 3", got);
        end
        for (int i = 0; i < got; i++) begin
            total++;
            if (got_tag[i] !== 64'(i + 1) || got_imm[i] !== b_imm[i]) begin
                bad++;
                $display("[TB] FAIL bp_order%0d: got tag=%h imm=%h expected tag=%h imm=%h",
                         i, got_tag[i], got_imm[i], 64'(i + 1), b_imm[i]);
            end
        end
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL bp_dup: got valid=%b tag=%h expected valid=0", bus.out_valid, bus.tag_out);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b1;
            bus.inst     = 32'hFFF00093;
            bus.fmt_op   = FMT_I;
            bus.tag_in   = 64'hA + 64'(i);
        end
        @(posedge clk);
        #1;
        bus.tag_in = 64'hC;
        bus.flush  = 1'b1;
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_full: got ready=%b valid=%b expected ready=0 valid=1",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_after: got valid=%b ready=%b expected valid=0 ready=1",
                     bus.out_valid, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL flush_leak: got valid=%b tag=%h expected valid=0", bus.out_valid, bus.tag_out);
            end
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.inst     = 32'h800000B7;
        bus.fmt_op   = FMT_AUTO;
        bus.tag_in   = 64'h55;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.tag_out !== 64'h55) begin
            bad++;
            $display("[TB] FAIL rmid_pre: got valid=%b tag=%h expected valid=1 tag=55", bus.out_valid, bus.tag_out);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0 || bus.imm_val !== 64'h0 ||
            bus.tag_out !== 64'h0 || bus.fmt_err !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmid_during: got v=%b r=%b imm=%h tag=%h err=%b expected all zero",
                     bus.out_valid, bus.in_ready, bus.imm_val, bus.tag_out, bus.fmt_err);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (bus.out_valid !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rmid_stale: got valid=%b tag=%h expected valid=0", bus.out_valid, bus.tag_out);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.inst     = 32'h02000223;
        bus.fmt_op   = FMT_AUTO;
        bus.tag_in   = 64'h66;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bus.out_valid !== 1'b1 || bus.tag_out !== 64'h66 || bus.imm_val !== 64'h24) begin
            bad++;
            $display("[TB] FAIL rmid_resume: got v=%b tag=%h imm=%h expected v=1 tag=66 imm=24",
                     bus.out_valid, bus.tag_out, bus.imm_val);
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_xlen32();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
